cacheline_adapter: RTL and testbench

- Sits directly downstream of the data cache, between its 256-bit line port and the 64-bit burst physical memory.
- Converts one line read or line write into a burst of BEATS 64-bit transfers, with the lowest-addressed beat first.
- Presents a single-cycle completion pulse back to the cache.
- Holds no data across transactions; it is purely a line/burst serialiser with a small state machine.

---
 rtl/cacheline_adapter.sv | 152 +++++++++++++++
 tb/tb_cacheline_adapter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cacheline_adapter.sv
`default_nettype none
// ============================================================================
//  Module      : cacheline_adapter
//  Description : Serialises one 256-bit cache line read or write into a burst
//                of 64-bit memory beats, lowest-addressed beat first, and
//                returns a single-cycle completion pulse to the cache.
//  Revision    : 1.0  initial release
// ============================================================================
module cacheline_adapter #(
  parameter int LINE_W   = 256,
  parameter int BEAT_W   = 64,
  parameter int BEATS    = 4,
  parameter int OFFSET_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  // cache line side
  input  logic [31:0]       line_address,
  input  logic              line_read,
  input  logic              line_write,
  input  logic [LINE_W-1:0] line_wdata,
  output logic [LINE_W-1:0] line_rdata,
  output logic              line_resp,
  // memory burst side
  output logic [31:0]       burst_address,
  output logic              burst_read,
  output logic              burst_write,
  output logic [BEAT_W-1:0] burst_wdata,
  input  logic [BEAT_W-1:0] burst_rdata,
  input  logic              burst_resp
);

  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [CNT_W-1:0] C_CNT_LAST  = CNT_W'(BEATS - 1);
  localparam logic [31:0]      C_ADDR_MASK = ~((32'd1 << OFFSET_W) - 32'd1);

  logic [1:0]        r_state;
  logic [1:0]        w_state_next;
  logic [CNT_W-1:0]  r_count;
  logic [31:0]       r_addr;
  logic [LINE_W-1:0] r_wline;
  logic [LINE_W-1:0] r_rline;

  logic              w_in_idle;
  logic              w_accept_wr;
  logic              w_accept_rd;
  logic              w_accept;
  logic              w_beat;
  logic              w_last_beat;
  logic [BEAT_W-1:0] w_wbeats [BEATS];

  // Write requests win over reads when both are raised in the same cycle.
  assign w_in_idle   = (r_state == ST_IDLE);
  assign w_accept_wr = w_in_idle & line_write;
  assign w_accept_rd = w_in_idle & ~line_write & line_read;
  assign w_accept    = w_accept_wr | w_accept_rd;

  // A beat is only consumed while a burst is actually in flight.
  assign w_beat      = burst_resp & ((r_state == ST_READ) | (r_state == ST_WRITE));
  assign w_last_beat = w_beat & (r_count == C_CNT_LAST);

  // Split the latched write line into beat-sized words, beat 0 at the LSBs.
  for (genvar gi = 0; gi < BEATS; gi++) begin : g_wbeat
    assign w_wbeats[gi] = r_wline[gi*BEAT_W +: BEAT_W];
  end

  // Next-state selection for the transaction sequencer.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept_wr) begin
          w_state_next = ST_WRITE;
        end else if (w_accept_rd) begin
          w_state_next = ST_READ;
        end
      end
      ST_READ: begin
        if (w_last_beat) begin
          w_state_next = ST_DONE;
        end
      end
      ST_WRITE: begin
        if (w_last_beat) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // State register and beat counter; the counter wraps after the last beat.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_count <= '0;
      end else if (w_beat) begin
        r_count <= w_last_beat ? '0 : (r_count + 1'b1);
      end
    end
  end

  // Capture address and write data once, at acceptance; later changes are ignored.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_addr  <= '0;
      r_wline <= '0;
    end else if (w_accept) begin
      r_addr <= line_address & C_ADDR_MASK;
      if (w_accept_wr) begin
        r_wline <= line_wdata;
      end
    end
  end

  // Assemble returning read beats into the line buffer at the counter's slot.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rline <= '0;
    end else if (w_beat && (r_state == ST_READ)) begin
      for (int i = 0; i < BEATS; i++) begin
        if (r_count == CNT_W'(i)) begin
          r_rline[i*BEAT_W +: BEAT_W] <= burst_rdata;
        end
      end
    end
  end

  assign burst_read    = (r_state == ST_READ);
  assign burst_write   = (r_state == ST_WRITE);
  assign line_resp     = (r_state == ST_DONE);
  assign burst_address = r_addr;
  assign burst_wdata   = burst_write ? w_wbeats[r_count] : '0;
  assign line_rdata    = r_rline;

endmodule
`default_nettype wire

// File: tb/tb_cacheline_adapter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cacheline_adapter
//  Description : Scoreboard bench for cacheline_adapter with a reactive
//                burst-memory model and randomized line transactions.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cacheline_adapter;

  localparam int LINE_W = 256;
  localparam int BEAT_W = 64;
  localparam int BEATS  = 4;

  logic              clk;
  logic              rst;
  logic [31:0]       line_address;
  logic              line_read;
  logic              line_write;
  logic [LINE_W-1:0] line_wdata;
  logic [LINE_W-1:0] line_rdata;
  logic              line_resp;
  logic [31:0]       burst_address;
  logic              burst_read;
  logic              burst_write;
  logic [BEAT_W-1:0] burst_wdata;
  logic [BEAT_W-1:0] burst_rdata;
  logic              burst_resp;

  cacheline_adapter #(
    .LINE_W(LINE_W), .BEAT_W(BEAT_W), .BEATS(BEATS), .OFFSET_W(5)
  ) dut (
    .clk(clk), .rst(rst),
    .line_address(line_address), .line_read(line_read), .line_write(line_write),
    .line_wdata(line_wdata), .line_rdata(line_rdata), .line_resp(line_resp),
    .burst_address(burst_address), .burst_read(burst_read), .burst_write(burst_write),
    .burst_wdata(burst_wdata), .burst_rdata(burst_rdata), .burst_resp(burst_resp)
  );

  typedef struct {
    logic         is_wr;
    logic [255:0] line;
    int           req_cyc;
    int           lat;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Current transaction as seen by the memory model.
  logic          cur_is_write;
  logic [31:0]   cur_addr;
  logic [255:0]  cur_wline;
  logic [63:0]   cur_rbeats [BEATS];
  int            cur_stall  [BEATS];
  int            mem_idx;
  int            stall_left;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Burst memory: answers each active cycle with a beat unless a stall is pending.
  initial begin
    burst_resp  = 1'b0;
    burst_rdata = '0;
    mem_idx     = 0;
    stall_left  = 0;
    forever begin
      @(posedge clk); #2;
      if (burst_read || burst_write) begin
        check("burst_dir_write", 256'(burst_write), 256'(cur_is_write));
        check("burst_dir_read", 256'(burst_read), 256'(!cur_is_write));
        check("burst_address", 256'(burst_address), 256'(cur_addr));
        if (mem_idx >= BEATS) begin
          checks++;
          errors++;
          $display("FAIL extra_beat: actual=%0d beats required=%0d", mem_idx + 1, BEATS);
          burst_resp  = 1'b1;
          burst_rdata = {$urandom, $urandom};
        end else if (stall_left > 0) begin
          stall_left--;
          burst_resp  = 1'b0;
          burst_rdata = {$urandom, $urandom};
          if (burst_write)
            check("wdata_hold", 256'(burst_wdata), 256'(cur_wline[mem_idx*64 +: 64]));
        end else begin
          burst_resp = 1'b1;
          if (burst_write) begin
            check("wdata_beat", 256'(burst_wdata), 256'(cur_wline[mem_idx*64 +: 64]));
            burst_rdata = {$urandom, $urandom};
          end else begin
            burst_rdata = cur_rbeats[mem_idx];
          end
          mem_idx++;
          stall_left = (mem_idx < BEATS) ? cur_stall[mem_idx] : 0;
        end
      end else begin
        mem_idx     = 0;
        stall_left  = cur_stall[0];
        burst_resp  = 1'($urandom_range(0, 1));
        burst_rdata = {$urandom, $urandom};
      end
    end
  end

  // Monitor: checks every completion against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      check("rw_exclusive", 256'(burst_read & burst_write), 256'(0));
      if (line_resp) begin
        check("done_burst_idle", 256'({burst_read, burst_write}), 256'(0));
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp: actual=1 required=0 (cycle %0d)", cyc);
        end else begin
          e = exp_q.pop_front();
          if (!e.is_wr) check("line_rdata", line_rdata, e.line);
          check("latency", 256'(cyc - e.req_cyc + 1), 256'(e.lat));
        end
      end
    end
  end

  task automatic check_outputs_zero(input string tag);
    check({tag, "_line_resp"}, 256'(line_resp), 256'(0));
    check({tag, "_burst_read"}, 256'(burst_read), 256'(0));
    check({tag, "_burst_write"}, 256'(burst_write), 256'(0));
    check({tag, "_burst_address"}, 256'(burst_address), 256'(0));
    check({tag, "_burst_wdata"}, 256'(burst_wdata), 256'(0));
    check({tag, "_line_rdata"}, line_rdata, 256'(0));
  endtask

  task automatic set_current(input logic wr, input logic [31:0] addr, input logic [255:0] wline,
                             input logic [255:0] rline, input int s0, input int s1,
                             input int s2, input int s3);
    cur_is_write = wr;
    cur_addr     = addr & 32'hFFFF_FFE0;
    cur_wline    = wline;
    for (int i = 0; i < BEATS; i++) cur_rbeats[i] = rline[i*64 +: 64];
    cur_stall[0] = s0;
    cur_stall[1] = s1;
    cur_stall[2] = s2;
    cur_stall[3] = s3;
  endtask

  // One complete line transaction; called right after a rising edge.
  task automatic run_txn(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [255:0] wline, input logic [255:0] rline,
                         input int s0, input int s1, input int s2, input int s3);
    exp_t e;
    bit   got;
    set_current(wr, addr, wline, rline, s0, s1, s2, s3);
    e.is_wr   = wr;
    e.line    = rline;
    e.req_cyc = cyc;
    e.lat     = 2 + BEATS + s0 + s1 + s2 + s3;
    exp_q.push_back(e);
    line_read    = rd;
    line_write   = wr;
    line_address = addr;
    line_wdata   = wline;
    @(posedge clk); #1;
    line_address = $urandom;
    line_wdata   = rand256();
    got = 1'b0;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk);
      if (line_resp) got = 1'b1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL resp_timeout: actual=none required=line_resp addr=%0h", addr);
    end
    @(posedge clk); #1;
    line_read  = 1'b0;
    line_write = 1'b0;
    repeat (1 + $urandom_range(0, 2)) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [255:0] rline_a;
    logic [255:0] wline_a;
    rline_a = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
    wline_a = {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}};

    rst          = 1'b0;
    line_read    = 1'b0;
    line_write   = 1'b0;
    line_address = '0;
    line_wdata   = '0;
    set_current(1'b0, 32'h0, '0, '0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Back-to-back read, then the same read with a 2-cycle stall mid-burst.
    run_txn(1'b1, 1'b0, 32'h8000_0A3C, '0, rline_a, 0, 0, 0, 0);
    run_txn(1'b1, 1'b0, 32'h8000_0A3C, '0, rline_a, 0, 2, 0, 0);
    // Line write with stalls so each beat must be held.
    run_txn(1'b0, 1'b1, 32'h0000_0100, wline_a, '0, 1, 0, 1, 0);
    // Both requests raised: write path wins.
    run_txn(1'b1, 1'b1, 32'h0000_2000, rand256(), '0, 0, 0, 0, 0);

    // Reset in the middle of a read, after two beats have been accepted.
    set_current(1'b0, 32'h0000_1040, '0, rand256(), 0, 0, 0, 0);
    line_read    = 1'b1;
    line_address = 32'h0000_1040;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b0;
    @(posedge clk); #1;
    rst       = 1'b1;
    line_read = 1'b0;
    check_outputs_zero("midreset");
    @(posedge clk); #1;
    run_txn(1'b1, 1'b0, 32'h0000_1040, '0, rand256(), 0, 0, 0, 0);

    // Randomized mix of reads, writes and simultaneous requests with stalls.
    for (int t = 0; t < 40; t++) begin
      int kind;
      int s [4];
      kind = $urandom_range(0, 2);
      for (int i = 0; i < 4; i++)
        s[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      run_txn(kind != 1, kind != 0, $urandom, rand256(), rand256(), s[0], s[1], s[2], s[3]);
    end

    repeat (3) @(posedge clk);
    check("queue_drained", 256'(exp_q.size()), 256'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
